pulse_period_monitor: RTL and testbench
=======================================

Name: pulse_period_monitor

Overview:
- Receive-side checker for a single-cycle periodic pulse train, such as the output of the team's regular-pulse generator.
- Detects pulse starts, measures the start-to-start interval, checks it against the expected period, and flags early, late, missing and over-wide pulses.
- Reports lock status and saturating good/error counters.
- Sits beside the generator in lab benches and on-board self-check paths.

Parameters:
- PERIOD, 10, expected cycles between consecutive pulse starts; must be at least 2.
- CNT_W, 16, width of the interval and statistics counters; 2*PERIOD must be less than 2^CNT_W.
- LOCK_N, 3, consecutive good periods required to assert locked; must be at least 1.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- enable  input  1  monitor enable; low forces SEARCH.
- pulse_in  input  1  pulse train under test, synchronous to clk.
- locked  output  1  high while LOCK_N or more consecutive good periods have been seen and no error has occurred since.
- period_valid  output  1  one-cycle strobe; measured_period was updated.
- measured_period  output  CNT_W  last completed start-to-start interval.
- period_err  output  1  one-cycle strobe; early, late or missing pulse.
- width_err  output  1  one-cycle strobe; pulse high for 2 or more cycles.
- good_count  output  CNT_W  saturating count of good periods.
- err_count  output  CNT_W  saturating count of period_err and width_err events.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All outputs 0; state SEARCH.
  - Interval counter, streak counter and previous-sample register cleared to 0.
- Edges and registering:
  - Start event S: pulse_in sampled 1 at this edge and 0 at the previous edge.
  - All outputs are registered and update at the edge where the event is sampled.
- Interval counter:
  - Loads 1 on S.
  - Otherwise increments by 1 each edge, saturating at all-ones.
- Comparison: evaluations use the counter value before that edge's update (P cycles between starts gives counter == P).
- State SEARCH:
  - On S (enable high): go to MEASURE and load the counter.
  - No period check, streak = 0, locked = 0.
- State MEASURE, on S:
  - measured_period <= counter; period_valid = 1.
  - If counter == PERIOD: good_count++ and streak++ (streak saturates at LOCK_N). locked = 1 once streak reaches LOCK_N.
  - Otherwise (early): period_err = 1, err_count++, streak = 0, locked = 0. Stay in MEASURE; this S becomes the new reference.
- State MEASURE, no S, counter == 2*PERIOD (missing/late):
  - period_err = 1, err_count++, streak = 0, locked = 0.
  - Go to SEARCH; no period_valid.
- Width check:
  - pulse_in sampled 1 on two consecutive edges gives width_err = 1 on the second edge only (once per pulse, whatever the length).
  - Also err_count++, streak = 0, locked = 0.
  - Active in both states while enable is high; the state is unaffected.
- Simultaneous width_err and period_err on the same edge: both strobes assert; err_count increments by 1 only.
- enable low:
  - Synchronous: state SEARCH, streak = 0, locked = 0, no strobes.
  - Counters and measured_period hold.
  - The previous-sample register keeps tracking pulse_in, so no false S is seen on re-enable.
- Counter saturation: good_count and err_count hold at all-ones.
- Reset mid-operation: immediate return to the reset values; the first pulse after release is treated as a first S (no period check).

Test Plan:
- Ideal train, period 10 (starts at cycles 5, 15, 25, 35):
  - period_valid at 15, 25 and 35, with measured_period = 10 each time.
  - good_count reaches 3 at 35; locked rises at 35.
  - No error strobes.
- Locked train, then one start 7 cycles after the previous one:
  - period_valid with measured_period = 7 and period_err = 1 on the same edge.
  - locked falls; err_count = 1.
  - Next start 10 cycles later gives a good period; locked returns after 3 good periods.
- Locked train, then the pulse stops:
  - period_err exactly 20 cycles after the last start; state SEARCH, locked = 0, no period_valid.
  - Resumed pulses: the first start gives no check; the second gives measured_period = 10.
- Locked train, one pulse held high for 3 cycles:
  - width_err exactly once, on its second high cycle.
  - err_count +1; locked drops; the next period is still measured as 10.
- Locked train:
  - rst_n low mid-period: all outputs 0 immediately.
  - Release, then enable low for 30 cycles: no strobes, counters hold.
  - Re-enable: the first start gives no check.
- Counter saturation: force CNT_W = 4 with 20 good periods → good_count holds at 15.

Source files
------------

// File: rtl/pulse_period_monitor.sv
// Receive-side checker for a single-cycle periodic pulse train: measures the
// start-to-start interval, flags early/late/missing/over-wide pulses, tracks lock.
module pulse_period_monitor #(
    parameter int PERIOD = 10,
    parameter int CNT_W  = 16,
    parameter int LOCK_N = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             pulse_in,
    output logic             locked,
    output logic             period_valid,
    output logic [CNT_W-1:0] measured_period,
    output logic             period_err,
    output logic             width_err,
    output logic [CNT_W-1:0] good_count,
    output logic [CNT_W-1:0] err_count
);
    // state   | meaning
    // SEARCH  | waiting for a first start; no period check
    // MEASURE | reference start seen; every start / timeout is checked
    typedef enum logic {SEARCH, MEASURE} state_t;

    localparam int SW = (LOCK_N < 2) ? 1 : $clog2(LOCK_N + 1);
    localparam logic [CNT_W-1:0] PER_C  = CNT_W'(PERIOD);
    localparam logic [CNT_W-1:0] MISS_C = CNT_W'(2 * PERIOD);
    localparam logic [CNT_W-1:0] ONES   = {CNT_W{1'b1}};
    localparam logic [SW-1:0]    LOCK_C = SW'(LOCK_N);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [SW-1:0]    streak;
    logic             prev, prev2;

    logic start, wide_ev, good_ev, early_ev, miss_ev, err_ev;
    logic [SW-1:0] streak_nxt;

    always_comb begin
        start      = pulse_in & ~prev;
        // prev2 keeps a long pulse from flagging more than once
        wide_ev    = enable & pulse_in & prev & ~prev2;
        good_ev    = enable & (state == MEASURE) & start & (cnt == PER_C);
        early_ev   = enable & (state == MEASURE) & start & (cnt != PER_C);
        miss_ev    = enable & (state == MEASURE) & ~start & (cnt == MISS_C);
        err_ev     = wide_ev | early_ev | miss_ev;
        streak_nxt = (streak == LOCK_C) ? streak : streak + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= SEARCH;
            cnt             <= '0;
            streak          <= '0;
            prev            <= 1'b0;
            prev2           <= 1'b0;
            locked          <= 1'b0;
            period_valid    <= 1'b0;
            measured_period <= '0;
            period_err      <= 1'b0;
            width_err       <= 1'b0;
            good_count      <= '0;
            err_count       <= '0;
        end else begin
            prev         <= pulse_in;
            prev2        <= prev;
            period_valid <= 1'b0;
            period_err   <= 1'b0;
            width_err    <= 1'b0;

            if (start)
                cnt <= CNT_W'(1);
            else if (cnt != ONES)
                cnt <= cnt + 1'b1;

            if (!enable) begin
                state  <= SEARCH;
                streak <= '0;
                locked <= 1'b0;
            end else begin
                if (start)
                    state <= MEASURE;
                else if (miss_ev)
                    state <= SEARCH;

                if (start && state == MEASURE) begin
                    period_valid    <= 1'b1;
                    measured_period <= cnt;
                end

                if (err_ev) begin
                    period_err <= early_ev | miss_ev;
                    width_err  <= wide_ev;
                    streak     <= '0;
                    locked     <= 1'b0;
                    if (err_count != ONES)
                        err_count <= err_count + 1'b1;
                end else if (good_ev) begin
                    streak <= streak_nxt;
                    locked <= (streak_nxt == LOCK_C);
                    if (good_count != ONES)
                        good_count <= good_count + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_pulse_period_monitor.sv
// Directed bench for pulse_period_monitor: ideal train, early, missing, wide,
// reset, enable gating and a narrow-counter saturation instance.
module tb_pulse_period_monitor;
    logic        clk = 1'b0;
    logic        rst_n, enable, pulse_in;
    logic        locked, period_valid, period_err, width_err;
    logic [15:0] measured_period, good_count, err_count;

    logic        enable2, pulse2;
    logic        locked2, pv2, pe2, we2;
    logic [3:0]  mp2, gc2, ec2;

    int n_cmp = 0;
    int n_err = 0;
    int n_pv, n_pe, n_we;

    always #5 clk = ~clk;

    pulse_period_monitor #(.PERIOD(10), .CNT_W(16), .LOCK_N(3)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .pulse_in(pulse_in),
        .locked(locked), .period_valid(period_valid), .measured_period(measured_period),
        .period_err(period_err), .width_err(width_err),
        .good_count(good_count), .err_count(err_count)
    );

    pulse_period_monitor #(.PERIOD(3), .CNT_W(4), .LOCK_N(3)) dut_sat (
        .clk(clk), .rst_n(rst_n), .enable(enable2), .pulse_in(pulse2),
        .locked(locked2), .period_valid(pv2), .measured_period(mp2),
        .period_err(pe2), .width_err(we2),
        .good_count(gc2), .err_count(ec2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input logic p);
        pulse_in = p;
        @(posedge clk);
        #1;
        n_pv += int'(period_valid);
        n_pe += int'(period_err);
        n_we += int'(width_err);
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) tick(1'b0);
    endtask

    task automatic clr_strobes();
        n_pv = 0; n_pe = 0; n_we = 0;
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b1; pulse_in = 1'b0;
        enable2 = 1'b1; pulse2 = 1'b0;
        clr_strobes();
        #12;
        chk("rst_locked", locked, 0);
        chk("rst_pv", period_valid, 0);
        chk("rst_mp", measured_period, 0);
        chk("rst_gc", good_count, 0);
        chk("rst_ec", err_count, 0);
        @(negedge clk) rst_n = 1'b1;

        // ideal train, starts at cycles 5, 15, 25, 35
        gap(4); tick(1'b1);
        chk("first_s_pv", period_valid, 0);
        gap(9); tick(1'b1);
        chk("p1_pv", period_valid, 1); chk("p1_mp", measured_period, 10);
        chk("p1_gc", good_count, 1);   chk("p1_lock", locked, 0);
        gap(9); tick(1'b1);
        chk("p2_gc", good_count, 2);   chk("p2_lock", locked, 0);
        gap(9); tick(1'b1);
        chk("p3_mp", measured_period, 10); chk("p3_gc", good_count, 3);
        chk("p3_lock", locked, 1);
        chk("ideal_no_err", n_pe + n_we, 0);
        chk("ideal_ec", err_count, 0);

        // early start, 7 cycles after previous
        gap(6); tick(1'b1);
        chk("early_pv", period_valid, 1); chk("early_mp", measured_period, 7);
        chk("early_pe", period_err, 1);   chk("early_lock", locked, 0);
        chk("early_ec", err_count, 1);
        gap(9); tick(1'b1);
        chk("after_early_pv", period_valid, 1); chk("after_early_mp", measured_period, 10);
        chk("after_early_gc", good_count, 4);   chk("after_early_lock", locked, 0);
        gap(9); tick(1'b1);
        chk("relock2", locked, 0);
        gap(9); tick(1'b1);
        chk("relock3", locked, 1); chk("relock_gc", good_count, 6);

        // missing pulse: timeout exactly 20 cycles after last start
        clr_strobes();
        gap(19);
        chk("miss_pe_early", n_pe, 0);
        tick(1'b0);
        chk("miss_pe", period_err, 1); chk("miss_pv", period_valid, 0);
        chk("miss_lock", locked, 0);   chk("miss_ec", err_count, 2);
        gap(3); tick(1'b1);
        chk("resume_first_pv", period_valid, 0); chk("resume_first_pe", period_err, 0);
        gap(9); tick(1'b1);
        chk("resume_pv", period_valid, 1); chk("resume_mp", measured_period, 10);
        chk("resume_gc", good_count, 7);
        gap(9); tick(1'b1);
        gap(9); tick(1'b1);
        chk("resume_lock", locked, 1);

        // pulse held high for 3 cycles
        gap(9); tick(1'b1);
        chk("wide_start_gc", good_count, 10); chk("wide_start_we", width_err, 0);
        clr_strobes();
        tick(1'b1);
        chk("wide_we", width_err, 1); chk("wide_ec", err_count, 3);
        chk("wide_lock", locked, 0);
        tick(1'b1);
        chk("wide_we_once", width_err, 0);
        gap(7); tick(1'b1);
        chk("wide_next_mp", measured_period, 10); chk("wide_next_pe", period_err, 0);
        chk("wide_next_gc", good_count, 11);     chk("wide_we_total", n_we, 1);
        gap(9); tick(1'b1);
        gap(9); tick(1'b1);
        chk("wide_relock", locked, 1);

        // asynchronous reset mid-period
        gap(4);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_lock", locked, 0); chk("arst_gc", good_count, 0);
        chk("arst_ec", err_count, 0); chk("arst_mp", measured_period, 0);
        @(negedge clk) rst_n = 1'b1;

        // disabled for 30 cycles with a live pulse train
        enable = 1'b0;
        clr_strobes();
        for (int i = 0; i < 3; i++) begin tick(1'b1); gap(9); end
        chk("dis_strobes", n_pv + n_pe + n_we, 0);
        chk("dis_gc", good_count, 0);
        enable = 1'b1;
        tick(1'b1);
        chk("reen_first_pv", period_valid, 0); chk("reen_first_pe", period_err, 0);
        gap(9); tick(1'b1);
        chk("reen_pv", period_valid, 1); chk("reen_gc", good_count, 1);
        gap(9); tick(1'b1);
        chk("reen_gc2", good_count, 2);

        // disable with nonzero counters: values hold, state forced to SEARCH
        enable = 1'b0;
        clr_strobes();
        gap(9); tick(1'b1); gap(15);
        chk("hold_strobes", n_pv + n_pe + n_we, 0);
        chk("hold_gc", good_count, 2); chk("hold_mp", measured_period, 10);
        chk("hold_ec", err_count, 0);  chk("hold_lock", locked, 0);
        enable = 1'b1;
        gap(4); tick(1'b1);
        chk("hold_reen_pv", period_valid, 0);

        // saturation on a 4-bit instance: 21 starts -> 20 good periods
        for (int i = 0; i < 21; i++) begin
            pulse2 = 1'b1; @(posedge clk); #1;
            pulse2 = 1'b0; @(posedge clk); #1;
            @(posedge clk); #1;
        end
        chk("sat_gc", gc2, 15);
        chk("sat_ec", ec2, 0);
        chk("sat_lock", locked2, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
